// File: rtl/mio_bus_responder.sv
// CPU-side memory/IO responder: one word request at a time, decoded into an external
// synchronous-read RAM, an LED register, the board switches and a free-running counter.
module mio_bus_responder #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CPU_MIO,
  input  logic              MemRW,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Data_write,
  output logic [31:0]       Data_read,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);

  state_t            state;
  state_t            state_next;

  logic [3:0]        req_region;
  logic [RAM_AW-1:0] req_word;
  logic [31:0]       req_data;
  logic              req_write;

  logic [31:0]       counter;
  logic [3:0]        wait_cnt;
  logic              wait_done;
  logic              accept;

  logic              sel_ram;
  logic              sel_led;
  logic              sel_sw;
  logic              sel_cnt;
  logic [31:0]       periph_rdata;

  // Only the region nibble and the word index are ever looked at again.
  logic              unused_addr;
  assign unused_addr = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0]};

  assign accept    = (state == IDLE) && CPU_MIO;
  assign wait_done = (wait_cnt == WAIT_LAST);

  assign sel_ram = (req_region == 4'h0);
  assign sel_led = (req_region == 4'hE);
  assign sel_sw  = (req_region == 4'hF) && !req_word[0];
  assign sel_cnt = (req_region == 4'hF) &&  req_word[0];

  assign ram_addr = req_word;
  assign ram_din  = req_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (CPU_MIO) state_next = ACCESS;
      ACCESS:  state_next = (sel_ram && !req_write) ? WAIT : RESP;
      WAIT:    if (wait_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The RAM write strobe is masked by rst so a store aborted in ACCESS never lands.
  always_comb begin
    MIO_ready = 1'b0;
    ram_we    = 1'b0;
    if (state == RESP) begin
      MIO_ready = 1'b1;
    end
    if ((state == ACCESS) && req_write && sel_ram && !rst) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_region <= 4'h0;
      req_word   <= '0;
      req_data   <= 32'h0;
      req_write  <= 1'b0;
    end else if (accept) begin
      req_region <= addr_bus[31:28];
      req_word   <= addr_bus[RAM_AW+1:2];
      req_data   <= Data_write;
      req_write  <= MemRW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'h0;
    end else if (state == ACCESS) begin
      wait_cnt <= 4'h0;
    end else if ((state == WAIT) && !wait_done) begin
      wait_cnt <= wait_cnt + 4'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= 32'h0;
    end else if ((state == ACCESS) && req_write && sel_cnt) begin
      counter <= req_data;
    end else begin
      counter <= counter + 32'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 16'h0;
    end else if ((state == ACCESS) && req_write && sel_led) begin
      led <= req_data[15:0];
    end
  end

  always_comb begin
    periph_rdata = 32'h0;
    if (sel_led) begin
      periph_rdata = {16'h0, led};
    end else if (sel_sw) begin
      periph_rdata = {16'h0, sw};
    end else if (sel_cnt) begin
      periph_rdata = counter;
    end
  end

  // Peripheral reads capture in ACCESS; RAM reads capture on the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      Data_read <= 32'h0;
    end else if ((state == ACCESS) && !req_write && !sel_ram) begin
      Data_read <= periph_rdata;
    end else if ((state == WAIT) && wait_done) begin
      Data_read <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized scoreboard bench for mio_bus_responder against a 1-cycle BRAM model.
module tb_mio_bus_responder;

  localparam int AW       = 10;
  localparam int WAIT_CYC = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          CPU_MIO = 1'b0;
  logic          MemRW = 1'b0;
  logic [31:0]   addr_bus = 32'h0;
  logic [31:0]   Data_write = 32'h0;
  logic [31:0]   Data_read;
  logic          MIO_ready;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic          ram_we;
  logic [31:0]   ram_dout;
  logic [15:0]   sw = 16'h0;
  logic [15:0]   led;

  mio_bus_responder #(.RAM_AW(AW), .RAM_WAIT(WAIT_CYC)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .MemRW(MemRW),
    .addr_bus(addr_bus), .Data_write(Data_write), .Data_read(Data_read),
    .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM: registered read, read-before-write.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct { int cyc; logic [31:0] data; logic [15:0] led; } resp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  resp_t exp_q[$];
  wr_t   we_q[$];

  logic [31:0] ref_ram [0:(1<<AW)-1];
  logic [15:0] ref_led = 16'h0;
  logic [31:0] last_read = 32'h0;
  logic [31:0] cnt_base_val = 32'h0;
  int          cnt_base_cyc = 0;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic report_fail(input string name, input int count);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d events, required 0 (cycle %0d)", name, count, cyc);
  endtask

  function automatic logic [31:0] cnt_at(input int c);
    return cnt_base_val + 32'(c - cnt_base_cyc);
  endfunction

  // Reference model: a request accepted in cycle t is applied to the abstract state here.
  task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int t);
    logic [3:0]    region;
    logic [AW-1:0] idx;
    logic [31:0]   d;
    int            rc;
    region = addr[31:28];
    idx    = addr[AW+1:2];
    rc     = t + 2;
    d      = 32'h0;
    if (we) begin
      case (region)
        4'h0: begin
          ref_ram[idx] = wdata;
          we_q.push_back('{t + 1, idx, wdata});
        end
        4'hE: ref_led = wdata[15:0];
        4'hF: if (addr[2]) begin
          cnt_base_val = wdata;
          cnt_base_cyc = t + 2;
        end
        default: ;
      endcase
      d = last_read;
    end else begin
      case (region)
        4'h0: begin
          d  = ref_ram[idx];
          rc = t + 2 + WAIT_CYC;
        end
        4'hE: d = {16'h0, ref_led};
        4'hF: d = addr[2] ? cnt_at(t + 1) : {16'h0, sw};
        default: d = 32'h0;
      endcase
      last_read = d;
    end
    exp_q.push_back('{rc, d, ref_led});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || we_q.size() != 0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || we_q.size() != 0) begin
      report_fail("timeout_outstanding", exp_q.size() + we_q.size());
      exp_q.delete();
      we_q.delete();
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    predict(we, addr, wdata, cyc);
    CPU_MIO    = 1'b1;
    MemRW      = we;
    addr_bus   = addr;
    Data_write = wdata;
    @(negedge clk);
    CPU_MIO    = 1'b0;
    MemRW      = 1'($urandom);
    addr_bus   = $urandom;
    Data_write = $urandom;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    CPU_MIO = 1'b0;
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    cnt_base_val = 32'h0;
    cnt_base_cyc = cyc;
    ref_led      = 16'h0;
    last_read    = 32'h0;
    exp_q.delete();
    we_q.delete();
  endtask

  // Monitor: compares every response and every RAM write strobe against the queues.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (MIO_ready) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected_ready", 1);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check_output("ready_cycle", 32'(cyc), 32'(e.cyc));
          check_output("read_data", Data_read, e.data);
          check_output("led_value", {16'h0, led}, {16'h0, e.led});
        end
      end
      if (ram_we) begin
        if (we_q.size() == 0) begin
          report_fail("unexpected_ram_we", 1);
        end else begin
          wr_t w;
          w = we_q.pop_front();
          check_output("ram_we_cycle", 32'(cyc), 32'(w.cyc));
          check_output("ram_addr", 32'(ram_addr), 32'(w.addr));
          check_output("ram_din", ram_din, w.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 32'h0;
      ref_ram[i] = 32'h0;
    end
    do_reset();
    mon_en = 1'b1;
    $display("[TB] reset released, idle checks");
    for (int i = 0; i < 5; i++) begin
      #2;
      check_output("idle_ready", 32'(MIO_ready), 32'h0);
      check_output("idle_data_read", Data_read, 32'h0);
      check_output("idle_led", {16'h0, led}, 32'h0);
      check_output("idle_ram_we", 32'(ram_we), 32'h0);
      @(negedge clk);
    end
    apply_stimulus(1'b0, 32'hF000_0004, 32'h0);

    $display("[TB] RAM store/load");
    apply_stimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 32'h0000_0010, 32'h0);

    $display("[TB] LED and switches");
    apply_stimulus(1'b1, 32'hE000_0000, 32'h0001_A5A5);
    apply_stimulus(1'b0, 32'hE000_0000, 32'h0);
    sw = 16'h1234;
    apply_stimulus(1'b0, 32'hF000_0000, 32'h0);

    $display("[TB] counter load and wrap");
    apply_stimulus(1'b1, 32'hF000_0004, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 32'hF000_0004, 32'h0);

    $display("[TB] unmapped and read-only regions");
    apply_stimulus(1'b0, 32'h3000_0000, 32'h0);
    apply_stimulus(1'b1, 32'hF000_0000, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 32'hF000_0000, 32'h0);
    apply_stimulus(1'b0, 32'hE000_0000, 32'h0);

    $display("[TB] back-to-back with CPU_MIO held high");
    @(negedge clk);
    t = cyc;
    for (int k = 0; k < 4; k++) predict(1'b0, 32'hF000_0004, 32'h0, t + 3 * k);
    CPU_MIO  = 1'b1;
    MemRW    = 1'b0;
    addr_bus = 32'hF000_0004;
    repeat (10) @(negedge clk);
    CPU_MIO = 1'b0;
    wait_idle();

    $display("[TB] reset during ACCESS of a RAM store");
    apply_stimulus(1'b1, 32'h0000_0040, 32'h1111_2222);
    @(negedge clk);
    CPU_MIO    = 1'b1;
    MemRW      = 1'b1;
    addr_bus   = 32'h0000_0040;
    Data_write = 32'h5555_AAAA;
    @(negedge clk);
    CPU_MIO = 1'b0;
    rst     = 1'b1;
    #2;
    check_output("abort_ram_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    rst          = 1'b0;
    cnt_base_val = 32'h0;
    cnt_base_cyc = cyc;
    ref_led      = 16'h0;
    last_read    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check_output("abort_no_ready", 32'(MIO_ready), 32'h0);
      @(negedge clk);
    end
    apply_stimulus(1'b0, 32'h0000_0040, 32'h0);
    apply_stimulus(1'b0, 32'hF000_0004, 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 80; i++) begin
      int r;
      sw = 16'($urandom);
      a  = $urandom;
      r  = $urandom_range(0, 4);
      case (r)
        0: begin a[31:28] = 4'h0; a[11:6] = 6'h0; end
        1: a[31:28] = 4'hE;
        2: begin a[31:28] = 4'hF; a[2] = 1'b0; end
        3: begin a[31:28] = 4'hF; a[2] = 1'b1; end
        default: a[31:28] = 4'($urandom_range(1, 13));
      endcase
      apply_stimulus(1'($urandom), a, $urandom);
    end

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0 || we_q.size() != 0) report_fail("leftover_expected", exp_q.size() + we_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
